// File: rtl/sa_operand_fetch.sv
// sa_operand_fetch: skewed scratchpad X/W operand requests and PE operand forwarding for the systolic array.
// Optional macro SA_FETCH_PERF_EN adds perf_req_cnt, a saturating count of issued lane requests.
module sa_operand_fetch #(
  parameter int unsigned N      = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned KLEN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_mul,
  input  logic [ADDR_W-1:0]   x_addr,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [ADDR_W-1:0]   x_stride,
  input  logic [ADDR_W-1:0]   w_stride,
  input  logic [KLEN_W-1:0]   k_len,
  input  logic [N-1:0]        lane_mask,
  output logic [N*ADDR_W-1:0] sc_x_queue,
  output logic [N*ADDR_W-1:0] sc_w_queue,
  output logic [N-1:0]        sc_valid_queue,
  input  logic [N*WORD_W-1:0] sc_x_data,
  input  logic [N*WORD_W-1:0] sc_w_data,
  output logic [N*WORD_W-1:0] pe_x_data,
  output logic [N*WORD_W-1:0] pe_w_data,
  output logic [N-1:0]        pe_valid,
  output logic                stall_mul,
  output logic                done
`ifdef SA_FETCH_PERF_EN
  ,
  output logic [31:0]         perf_req_cnt
`endif
);

  localparam int unsigned LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CYC_W  = ((KLEN_W > LANE_W) ? KLEN_W : LANE_W) + 1;
  localparam int unsigned DRN_W  = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t              state;
  logic [CYC_W-1:0]    cyc;
  logic [DRN_W-1:0]    drn;
  logic [ADDR_W-1:0]   x_q, w_q, xs_q, ws_q;
  logic [KLEN_W-1:0]   k_q;
  logic [N-1:0]        mask_q;

  logic                accept_c, last_c, req_on_c;
  logic [CYC_W-1:0]    req_cyc_c, k_off_c;
  logic [ADDR_W-1:0]   cx_c, cw_c, cxs_c, cws_c;
  logic [KLEN_W-1:0]   ck_c;
  logic [N-1:0]        cm_c;
  logic [N-1:0]        nxt_valid_c;
  logic [N*ADDR_W-1:0] nxt_x_c, nxt_w_c;

  assign accept_c  = (state == IDLE) && start_mul && (k_len != '0);
  assign last_c    = (cyc + CYC_W'(1)) == (CYC_W'(k_q) + CYC_W'(N - 1));
  assign req_on_c  = accept_c || ((state == FEED) && !last_c);
  assign req_cyc_c = accept_c ? '0 : cyc + CYC_W'(1);

  // The first request cycle is computed from the live inputs, later ones from the latched copy.
  assign cx_c  = accept_c ? x_addr    : x_q;
  assign cw_c  = accept_c ? w_addr    : w_q;
  assign cxs_c = accept_c ? x_stride  : xs_q;
  assign cws_c = accept_c ? w_stride  : ws_q;
  assign ck_c  = accept_c ? k_len     : k_q;
  assign cm_c  = accept_c ? lane_mask : mask_q;

  // Requests for the coming cycle; lane i is skewed by i cycles.
  always_comb begin
    nxt_valid_c = '0;
    nxt_x_c     = '0;
    nxt_w_c     = '0;
    k_off_c     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k_off_c = req_cyc_c - CYC_W'(i);
      if (req_on_c && cm_c[i] && (req_cyc_c >= CYC_W'(i)) &&
          (req_cyc_c < (CYC_W'(i) + CYC_W'(ck_c)))) begin
        nxt_valid_c[i]              = 1'b1;
        nxt_x_c[i*ADDR_W +: ADDR_W] = cx_c + ADDR_W'(i) * cxs_c + ADDR_W'(k_off_c);
        nxt_w_c[i*ADDR_W +: ADDR_W] = cw_c + ADDR_W'(i) * cws_c + ADDR_W'(k_off_c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cyc            <= '0;
      drn            <= '0;
      x_q            <= '0;
      w_q            <= '0;
      xs_q           <= '0;
      ws_q           <= '0;
      k_q            <= '0;
      mask_q         <= '0;
      sc_x_queue     <= '0;
      sc_w_queue     <= '0;
      sc_valid_queue <= '0;
      pe_x_data      <= '0;
      pe_w_data      <= '0;
      pe_valid       <= '0;
      stall_mul      <= 1'b0;
      done           <= 1'b0;
    end else begin
      done           <= 1'b0;
      sc_valid_queue <= nxt_valid_c;
      sc_x_queue     <= nxt_x_c;
      sc_w_queue     <= nxt_w_c;
      pe_valid       <= sc_valid_queue;
      // Read data arrives while pe_valid marks its lane; idle lanes forward zero.
      for (int unsigned i = 0; i < N; i++) begin
        pe_x_data[i*WORD_W +: WORD_W] <= pe_valid[i] ? sc_x_data[i*WORD_W +: WORD_W] : '0;
        pe_w_data[i*WORD_W +: WORD_W] <= pe_valid[i] ? sc_w_data[i*WORD_W +: WORD_W] : '0;
      end
      case (state)
        IDLE: begin
          if (start_mul) begin
            if (k_len != '0) begin
              x_q       <= x_addr;
              w_q       <= w_addr;
              xs_q      <= x_stride;
              ws_q      <= w_stride;
              k_q       <= k_len;
              mask_q    <= lane_mask;
              cyc       <= '0;
              stall_mul <= 1'b1;
              state     <= FEED;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FEED: begin
          if (last_c) begin
            drn   <= '0;
            state <= DRAIN;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        DRAIN: begin
          if (drn == DRN_W'(2 * N - 1)) begin
            stall_mul <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            drn <= drn + DRN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SA_FETCH_PERF_EN
  localparam int unsigned CNT_W = LANE_W + 1;

  logic [CNT_W-1:0] pop_c;
  logic [32:0]      sum_c;

  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop_c = pop_c + CNT_W'(sc_valid_queue[i]);
    end
    sum_c = 33'(perf_req_cnt) + 33'(pop_c);
  end

  // Saturating lane-request counter, restarted by every start taken in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_req_cnt <= '0;
    end else if ((state == IDLE) && start_mul) begin
      perf_req_cnt <= '0;
    end else begin
      perf_req_cnt <= sum_c[32] ? '1 : sum_c[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_sa_operand_fetch.sv
// tb_sa_operand_fetch: scoreboard bench for sa_operand_fetch at N=4 with a data=address scratchpad model.
`timescale 1ns/1ps
module tb_sa_operand_fetch;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned WW = 32;
  localparam int unsigned KW = 16;
  localparam logic [31:0] WOFS = 32'h1000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_mul;
  logic [AW-1:0]   x_addr, w_addr, x_stride, w_stride;
  logic [KW-1:0]   k_len;
  logic [N-1:0]    lane_mask;
  logic [N*AW-1:0] sc_x_queue, sc_w_queue;
  logic [N-1:0]    sc_valid_queue;
  logic [N*WW-1:0] sc_x_data, sc_w_data;
  logic [N*WW-1:0] pe_x_data, pe_w_data;
  logic [N-1:0]    pe_valid;
  logic            stall_mul, done;
`ifdef SA_FETCH_PERF_EN
  logic [31:0]     perf_req_cnt;
`endif

  sa_operand_fetch #(.N(N), .ADDR_W(AW), .WORD_W(WW), .KLEN_W(KW)) dut (
    .clk(clk), .rst(rst), .start_mul(start_mul),
    .x_addr(x_addr), .w_addr(w_addr), .x_stride(x_stride), .w_stride(w_stride),
    .k_len(k_len), .lane_mask(lane_mask),
    .sc_x_queue(sc_x_queue), .sc_w_queue(sc_w_queue), .sc_valid_queue(sc_valid_queue),
    .sc_x_data(sc_x_data), .sc_w_data(sc_w_data),
    .pe_x_data(pe_x_data), .pe_w_data(pe_w_data), .pe_valid(pe_valid),
    .stall_mul(stall_mul), .done(done)
`ifdef SA_FETCH_PERF_EN
    , .perf_req_cnt(perf_req_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scratchpad: one-cycle latency, X returns the address, W returns address + WOFS.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      sc_x_data[i*WW +: WW] <= sc_x_queue[i*AW +: AW];
      sc_w_data[i*WW +: WW] <= sc_w_queue[i*AW +: AW] + WOFS;
    end
  end

  typedef struct {
    int          cyc;
    int          lane;
    logic [31:0] x;
    logic [31:0] w;
  } req_t;

  req_t req_q[$];
  req_t pe_q[$];
  int   done_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   started = 1'b0;

  // Hand-computed requests for x=0x100 xs=3, w=0x200 ws=0x10, k=3, all lanes.
  int          h_cyc [12] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 5};
  int          h_lane[12] = '{0, 0, 1, 0, 1, 2, 1, 2, 3, 2, 3, 3};
  logic [31:0] h_x   [12] = '{32'h100, 32'h101, 32'h103, 32'h102, 32'h104, 32'h106,
                              32'h105, 32'h107, 32'h109, 32'h108, 32'h10A, 32'h10B};
  logic [31:0] h_w   [12] = '{32'h200, 32'h201, 32'h210, 32'h202, 32'h211, 32'h220,
                              32'h212, 32'h221, 32'h230, 32'h222, 32'h231, 32'h232};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_req(input int c, input int i, input logic [31:0] xa, input logic [31:0] wa,
                          input int pe_limit);
    req_t e;
    e.cyc = c; e.lane = i; e.x = xa; e.w = wa;
    req_q.push_back(e);
    if (c < pe_limit) begin
      e.w = wa + WOFS;
      pe_q.push_back(e);
    end
  endtask

  task automatic push_tile(input logic [31:0] xa, input logic [31:0] wa, input logic [31:0] xs,
                           input logic [31:0] ws, input int k, input logic [N-1:0] m,
                           input int req_limit);
    for (int c = 0; c <= k + N - 2 && c <= req_limit; c++)
      for (int i = 0; i < N; i++)
        if (m[i] && c >= i && c < i + k)
          push_req(c, i, xa + 32'(i) * xs + 32'(c - i), wa + 32'(i) * ws + 32'(c - i), req_limit);
    if (req_limit >= k + N) done_q.push_back((k == 0) ? 0 : k + 3 * N - 1);
  endtask

  // Called just after a rising edge; start is seen on the following edge.
  task automatic pulse(input logic [31:0] xa, input logic [31:0] wa, input logic [31:0] xs,
                       input logic [31:0] ws, input logic [KW-1:0] k, input logic [N-1:0] m);
    x_addr = xa; w_addr = wa; x_stride = xs; w_stride = ws; k_len = k; lane_mask = m;
    start_mul = 1'b1;
    @(posedge clk); #1;
    start_mul = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      if (done) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: done not seen within 400 cycles", name);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, " sc_valid"}, 128'(sc_valid_queue), 128'(0));
    check({name, " sc_x"}, 128'(sc_x_queue), 128'(0));
    check({name, " pe_valid"}, 128'(pe_valid), 128'(0));
    check({name, " pe_x"}, 128'(pe_x_data), 128'(0));
    check({name, " stall"}, 128'(stall_mul), 128'(0));
    check({name, " done"}, 128'(done), 128'(0));
  endtask

  // Monitor: pops expectations whenever the DUT presents requests, operands or done.
  int          fc = 0;
  int          stall_len = 0;
  logic        prev_stall = 1'b0;
  logic [N-1:0] pend = '0;
  logic [N-1:0] pend_n;
  logic [31:0] pend_x[N];
  logic [31:0] pend_w[N];
  req_t        me;

  always @(negedge clk) begin
    if (started) begin
      if (stall_mul && !prev_stall) fc = 0;
      else if (stall_mul) fc++;
      pend_n = '0;
      for (int i = 0; i < N; i++) begin
        checks++;
        if (pend[i]) begin
          if (pe_x_data[i*WW +: WW] !== pend_x[i] || pe_w_data[i*WW +: WW] !== pend_w[i]) begin
            errors++;
            $display("FAIL pe_data lane %0d: got x=%h w=%h expected x=%h w=%h", i,
                     pe_x_data[i*WW +: WW], pe_w_data[i*WW +: WW], pend_x[i], pend_w[i]);
          end
        end else if (pe_x_data[i*WW +: WW] !== 32'h0 || pe_w_data[i*WW +: WW] !== 32'h0) begin
          errors++;
          $display("FAIL pe_idle lane %0d: got x=%h w=%h expected 0", i,
                   pe_x_data[i*WW +: WW], pe_w_data[i*WW +: WW]);
        end
        checks++;
        if (sc_valid_queue[i]) begin
          if (req_q.size() == 0) begin
            errors++;
            $display("FAIL req lane %0d: unexpected request x=%h at feed cycle %0d", i,
                     sc_x_queue[i*AW +: AW], fc);
          end else begin
            me = req_q.pop_front();
            if (me.cyc != fc || me.lane != i || sc_x_queue[i*AW +: AW] !== me.x ||
                sc_w_queue[i*AW +: AW] !== me.w) begin
              errors++;
              $display("FAIL req: got cyc=%0d lane=%0d x=%h w=%h expected cyc=%0d lane=%0d x=%h w=%h",
                       fc, i, sc_x_queue[i*AW +: AW], sc_w_queue[i*AW +: AW],
                       me.cyc, me.lane, me.x, me.w);
            end
          end
        end else if (sc_x_queue[i*AW +: AW] !== 32'h0 || sc_w_queue[i*AW +: AW] !== 32'h0) begin
          errors++;
          $display("FAIL req_idle lane %0d: got x=%h w=%h expected 0", i,
                   sc_x_queue[i*AW +: AW], sc_w_queue[i*AW +: AW]);
        end
        if (pe_valid[i]) begin
          checks++;
          if (pe_q.size() == 0) begin
            errors++;
            $display("FAIL pe_valid lane %0d: unexpected at feed cycle %0d", i, fc);
          end else begin
            me = pe_q.pop_front();
            if (me.cyc + 1 != fc || me.lane != i) begin
              errors++;
              $display("FAIL pe_valid: got cyc=%0d lane=%0d expected cyc=%0d lane=%0d",
                       fc, i, me.cyc + 1, me.lane);
            end
            pend_n[i] = 1'b1;
            pend_x[i] = me.x;
            pend_w[i] = me.w;
          end
        end
      end
      pend = pend_n;
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done: unexpected pulse, got stall_len=%0d expected none", stall_len);
        end else begin
          me.cyc = done_q.pop_front();
          if (stall_len != me.cyc) begin
            errors++;
            $display("FAIL stall_len: got %0d expected %0d", stall_len, me.cyc);
          end
        end
        stall_len = 0;
      end else if (stall_mul) begin
        stall_len++;
      end
      prev_stall = stall_mul;
      if (rst) begin
        pend = '0;
        stall_len = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; start_mul = 1'b0;
    x_addr = '0; w_addr = '0; x_stride = '0; w_stride = '0; k_len = '0; lane_mask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    started = 1'b1;
    check_quiet("reset");

    // Hand-computed tile: 14 stall cycles.
    @(posedge clk); #1;
    for (int j = 0; j < 12; j++) push_req(h_cyc[j], h_lane[j], h_x[j], h_w[j], 1000);
    done_q.push_back(14);
    pulse(32'h100, 32'h200, 32'd3, 32'h10, 16'd3, 4'b1111);
    wait_done("tile_hand");
`ifdef SA_FETCH_PERF_EN
    check("perf_full", 128'(perf_req_cnt), 128'(12));
`endif

    // Masked lanes 1 and 3.
    @(posedge clk); #1;
    push_tile(32'h40, 32'h800, 32'd8, 32'd4, 3, 4'b0101, 1000);
    pulse(32'h40, 32'h800, 32'd8, 32'd4, 16'd3, 4'b0101);
    wait_done("tile_mask");
`ifdef SA_FETCH_PERF_EN
    check("perf_mask", 128'(perf_req_cnt), 128'(6));
`endif

    // k_len = 0: done only, no stall.
    @(posedge clk); #1;
    push_tile(32'h500, 32'h600, 32'd1, 32'd1, 0, 4'b1111, 1000);
    pulse(32'h500, 32'h600, 32'd1, 32'd1, 16'd0, 4'b1111);
    check("k0 stall", 128'(stall_mul), 128'(0));
    wait_done("tile_k0");

    // Address wrap modulo 2^32.
    @(posedge clk); #1;
    push_tile(32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'd1, 32'h20, 4, 4'b1011, 1000);
    pulse(32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'd1, 32'h20, 16'd4, 4'b1011);
    wait_done("tile_wrap");

    // start re-pulsed during DRAIN is ignored.
    @(posedge clk); #1;
    push_tile(32'h700, 32'h900, 32'd2, 32'd5, 2, 4'b1111, 1000);
    pulse(32'h700, 32'h900, 32'd2, 32'd5, 16'd2, 4'b1111);
    repeat (6) begin @(posedge clk); #1; end
    pulse(32'hABC0, 32'hDEF0, 32'd1, 32'd1, 16'd7, 4'b1111);
    wait_done("tile_drain_pulse");

    // Back-to-back: second start in the done cycle.
    @(posedge clk); #1;
    push_tile(32'h1000, 32'h3000, 32'd4, 32'd4, 5, 4'b1111, 1000);
    pulse(32'h1000, 32'h3000, 32'd4, 32'd4, 16'd5, 4'b1111);
    wait_done("tile_b2b_first");
    push_tile(32'h2000, 32'h4000, 32'd1, 32'd2, 1, 4'b1111, 1000);
    pulse(32'h2000, 32'h4000, 32'd1, 32'd2, 16'd1, 4'b1111);
    check("b2b stall", 128'(stall_mul), 128'(1));
    wait_done("tile_b2b_second");

    // Reset during FEED cycle 2, then a clean tile.
    @(posedge clk); #1;
    push_tile(32'h800, 32'hC00, 32'd3, 32'd3, 3, 4'b1111, 2);
    pulse(32'h800, 32'hC00, 32'd3, 32'd3, 16'd3, 4'b1111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_quiet("mid_reset");
    check("mid_reset pe_w", 128'(pe_w_data), 128'(0));
    @(posedge clk); #1;
    check_quiet("post_reset");
    push_tile(32'h100, 32'h200, 32'd3, 32'h10, 3, 4'b1111, 1000);
    pulse(32'h100, 32'h200, 32'd3, 32'h10, 16'd3, 4'b1111);
    wait_done("tile_after_reset");

    repeat (6) begin @(posedge clk); #1; end
    check("req_q drained", 128'(req_q.size()), 128'(0));
    check("pe_q drained", 128'(pe_q.size()), 128'(0));
    check("done_q drained", 128'(done_q.size()), 128'(0));
    check_quiet("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
